clk_divgen_multi: RTL and testbench

- Parametrised successor to the single-output PLL clock wrapper: a fully synchronous, runtime-programmable multi-channel clock generator driven by refclk.
- Each of NUM_CLK channels produces a divided clock with programmable divide ratio, high time (duty) and phase offset.
- Exposes a locked indication and per-channel rising-edge strobes, so downstream logic can use either the derived clocks or refclk-domain clock enables.
- Sits between the board reference clock and the slow peripheral and display logic.

---
 rtl/clk_divgen_multi.sv | 162 ++++++++++++++++
 tb/tb_clk_divgen_multi.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_divgen_multi.sv
// Multi-channel programmable clock generator, fully synchronous to refclk.
// Each channel divides refclk by a programmable ratio with programmable high
// time and rising-edge phase offset. All channels restart together whenever
// any channel is reconfigured, and locked reports that channel 0 has completed
// LOCK_CYCLES periods since the last restart.
//
// Ports:
//   refclk       - sole clock, rising edge
//   rst          - synchronous active-high reset
//   cfg_valid    - configuration write request
//   cfg_ready    - configuration write accepted this cycle when high
//   cfg_chan     - target channel (values >= NUM_CLK are consumed and dropped)
//   cfg_div      - divide ratio (clamped to >= 2)
//   cfg_high     - high cycles per period (clamped to 1..div-1)
//   cfg_phase    - rising-edge delay in refclk cycles (clamped to <= div-1)
//   outclk       - divided clocks, one flop per bit
//   outclk_stb   - one-cycle pulse in the cycle each outclk rises
//   locked       - all channels running on a settled configuration
module clk_divgen_multi #(
  parameter int unsigned NUM_CLK     = 4,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned CH_W        = 2,
  parameter int unsigned LOCK_CYCLES = 8,
  parameter int unsigned DEFAULT_DIV = 10
) (
  input  logic               refclk,
  input  logic               rst,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [CH_W-1:0]    cfg_chan,
  input  logic [CNT_W-1:0]   cfg_div,
  input  logic [CNT_W-1:0]   cfg_high,
  input  logic [CNT_W-1:0]   cfg_phase,
  output logic [NUM_CLK-1:0] outclk,
  output logic [NUM_CLK-1:0] outclk_stb,
  output logic               locked
);

  localparam int unsigned      LockW   = 8;
  localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CntTwo  = CNT_W'(2);
  localparam logic [CNT_W-1:0] DefDiv  = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] DefHigh = CNT_W'(DEFAULT_DIV / 2);
  localparam logic [LockW-1:0] LockMax = LockW'(LOCK_CYCLES);
  localparam logic [LockW-1:0] LockOne = LockW'(1);

  typedef enum logic [1:0] {StStart, StRun, StLocked} state_e;

  state_e           state_q, state_d;
  logic [LockW-1:0] lock_cnt_q, lock_cnt_d;
  logic             cfg_ready_d, locked_d;

  // Per-channel configuration holds already-clamped values.
  logic [CNT_W-1:0] div_q   [NUM_CLK];
  logic [CNT_W-1:0] high_q  [NUM_CLK];
  logic [CNT_W-1:0] phase_q [NUM_CLK];
  logic [CNT_W-1:0] cnt_q   [NUM_CLK];
  logic [CNT_W-1:0] cnt_d   [NUM_CLK];
  logic [CNT_W-1:0] load_val[NUM_CLK];
  logic [NUM_CLK-1:0] wrap, clk_d, stb_d;

  logic [CNT_W-1:0] div_e, div_m1, high_e, phase_e;
  logic             cfg_fire, cfg_hit;

  // Clamp incoming configuration at capture.
  always_comb begin
    div_e  = (cfg_div < CntTwo) ? CntTwo : cfg_div;
    div_m1 = div_e - CntOne;
    if (cfg_high == '0) begin
      high_e = CntOne;
    end else if (cfg_high > div_m1) begin
      high_e = div_m1;
    end else begin
      high_e = cfg_high;
    end
    phase_e = (cfg_phase > div_m1) ? div_m1 : cfg_phase;
  end

  assign cfg_fire = cfg_valid & cfg_ready;
  assign cfg_hit  = cfg_fire & ({{(32 - CH_W){1'b0}}, cfg_chan} < NUM_CLK);

  // Outputs are computed from the next count so each outclk flop changes in
  // the same cycle as its counter.
  always_comb begin
    for (int i = 0; i < NUM_CLK; i++) begin
      wrap[i]     = (cnt_q[i] == div_q[i] - CntOne);
      load_val[i] = (phase_q[i] == '0) ? '0 : div_q[i] - phase_q[i];
      if (state_q == StStart) begin
        cnt_d[i] = load_val[i];
      end else if (wrap[i]) begin
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CntOne;
      end
      clk_d[i] = (cnt_d[i] < high_q[i]);
      stb_d[i] = (cnt_d[i] == '0);
    end
  end

  always_comb begin
    state_d    = state_q;
    lock_cnt_d = lock_cnt_q;
    if (state_q == StStart) begin
      lock_cnt_d = '0;
    end else if (wrap[0] && (lock_cnt_q < LockMax)) begin
      lock_cnt_d = lock_cnt_q + LockOne;
    end
    unique case (state_q)
      StStart: state_d = StRun;
      StRun: begin
        if (cfg_hit) begin
          state_d = StStart;
        end else if (lock_cnt_d == LockMax) begin
          state_d = StLocked;
        end
      end
      StLocked: begin
        if (cfg_hit) begin
          state_d = StStart;
        end
      end
      default: state_d = StStart;
    endcase
    // Status flags lag the state by one cycle, and drop immediately on a
    // restart, so ready/locked stay low across the whole restart window.
    cfg_ready_d = (state_q != StStart) && (state_d != StStart);
    locked_d    = (state_q == StLocked) && (state_d == StLocked);
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q    <= StStart;
      lock_cnt_q <= '0;
      cfg_ready  <= 1'b0;
      locked     <= 1'b0;
      outclk     <= '0;
      outclk_stb <= '0;
      for (int i = 0; i < NUM_CLK; i++) begin
        div_q[i]   <= DefDiv;
        high_q[i]  <= DefHigh;
        phase_q[i] <= '0;
        cnt_q[i]   <= '0;
      end
    end else begin
      state_q    <= state_d;
      lock_cnt_q <= lock_cnt_d;
      cfg_ready  <= cfg_ready_d;
      locked     <= locked_d;
      outclk     <= clk_d;
      outclk_stb <= stb_d;
      for (int i = 0; i < NUM_CLK; i++) begin
        cnt_q[i] <= cnt_d[i];
        if (cfg_hit && (cfg_chan == CH_W'(i))) begin
          div_q[i]   <= div_e;
          high_q[i]  <= high_e;
          phase_q[i] <= phase_e;
        end
      end
    end
  end

endmodule

// File: tb/tb_clk_divgen_multi.sv
// Self-checking bench for clk_divgen_multi (3 channels, so channel 3 is invalid).
// Expected waveforms come from a closed-form model: each channel's position in
// its period is derived from the time since the last restart.
module tb_clk_divgen_multi;

  localparam int NCH  = 3;
  localparam int LOCK = 8;
  localparam int DDIV = 10;

  logic        refclk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [1:0]  cfg_chan = '0;
  logic [15:0] cfg_div = '0, cfg_high = '0, cfg_phase = '0;
  logic [2:0]  outclk, outclk_stb;
  logic        locked;

  clk_divgen_multi #(
    .NUM_CLK(NCH), .CNT_W(16), .CH_W(2), .LOCK_CYCLES(LOCK), .DEFAULT_DIV(DDIV)
  ) dut (
    .refclk    (refclk),
    .rst       (rst),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_chan  (cfg_chan),
    .cfg_div   (cfg_div),
    .cfg_high  (cfg_high),
    .cfg_phase (cfg_phase),
    .outclk    (outclk),
    .outclk_stb(outclk_stb),
    .locked    (locked)
  );

  always #5 refclk = ~refclk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;   // observation index, sampled 1ns after each rising edge
  int t0 = 0;    // observation index of the most recent restart (cycle 0)
  int m_div[NCH], m_high[NCH], m_phase[NCH];
  logic [7:0] got, exp;

  task automatic tick();
    @(posedge refclk);
    #1;
    cyc++;
  endtask

  task automatic model_defaults();
    for (int c = 0; c < NCH; c++) begin
      m_div[c] = DDIV; m_high[c] = DDIV / 2; m_phase[c] = 0;
    end
  endtask

  // {outclk, outclk_stb, locked, cfg_ready} expected at observation t.
  function automatic logic [7:0] exp_vec(int t);
    logic [2:0] c, s;
    int d, pos, first, dt;
    dt = t - t0;
    for (int ch = 0; ch < NCH; ch++) begin
      d = m_div[ch];
      // Rising edge lands phase cycles after restart (or at restart for 0).
      pos = (dt + d - (m_phase[ch] % d)) % d;
      c[ch] = (pos < m_high[ch]);
      s[ch] = (pos == 0);
    end
    first = (m_phase[0] == 0) ? m_div[0] : m_phase[0];
    return {c, s, dt >= first + (LOCK - 1) * m_div[0] + 1, dt >= 1};
  endfunction

  // Hold a write until accepted; leaves the bench at the restart cycle.
  task automatic cfg_write(input int ch, input int div, input int high, input int phase);
    logic r;
    bit   acc;
    int   de, he, pe;
    acc = 0;
    cfg_valid = 1'b1;
    cfg_chan  = 2'(ch);
    cfg_div   = 16'(div);
    cfg_high  = 16'(high);
    cfg_phase = 16'(phase);
    for (int w = 0; w < 40 && !acc; w++) begin
      r = cfg_ready;
      tick();
      if (r === 1'b1) acc = 1;
    end
    cfg_valid = 1'b0;
    checks++;
    if (!acc) begin
      failures++;
      $display("FAIL cfg_write_timeout got=no_ready exp=ready_within_40");
    end else if (ch < NCH) begin
      de = (div < 2) ? 2 : div;
      he = (high < 1) ? 1 : high;
      if (he > de - 1) he = de - 1;
      pe = (phase > de - 1) ? de - 1 : phase;
      m_div[ch] = de; m_high[ch] = he; m_phase[ch] = pe;
      t0 = cyc + 1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) begin
      tick();
      checks++;
      got = {outclk, outclk_stb, locked, cfg_ready};
      if (got !== 8'h00) begin
        failures++;
        $display("FAIL reset_values got=%b exp=%b", got, 8'h00);
      end
    end
    rst = 1'b0;
    tick();
    t0 = cyc;
    model_defaults();
    for (int n = 0; n < 100; n++) begin
      got = {outclk, outclk_stb, locked, cfg_ready}; exp = exp_vec(cyc);
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL default_wave t=%0d got=%b exp=%b", cyc - t0, got, exp);
      end
      tick();
    end
  endtask

  task automatic test_reconfig();
    cfg_write(1, 4, 1, 2);
    checks++;
    if (locked !== 1'b0 || cfg_ready !== 1'b0) begin
      failures++;
      $display("FAIL reconfig_start got=%b%b exp=00", locked, cfg_ready);
    end
    for (int n = 0; n < 90; n++) begin
      tick();
      got = {outclk, outclk_stb, locked, cfg_ready}; exp = exp_vec(cyc);
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL reconfig_wave t=%0d got=%b exp=%b", cyc - t0, got, exp);
      end
    end
  endtask

  task automatic test_clamp();
    cfg_write(2, 0, 0, 0);
    for (int n = 0; n < 30; n++) begin
      tick();
      got = {outclk, outclk_stb, locked, cfg_ready}; exp = exp_vec(cyc);
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL clamp_div0 t=%0d got=%b exp=%b", cyc - t0, got, exp);
      end
    end
    cfg_write(0, 5, 9, 7);
    for (int n = 0; n < 45; n++) begin
      tick();
      got = {outclk, outclk_stb, locked, cfg_ready}; exp = exp_vec(cyc);
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL clamp_high_phase t=%0d got=%b exp=%b", cyc - t0, got, exp);
      end
    end
  endtask

  task automatic test_bad_chan();
    cfg_write(3, 7, 3, 1);
    for (int n = 0; n < 20; n++) begin
      got = {outclk, outclk_stb, locked, cfg_ready}; exp = exp_vec(cyc);
      checks++;
      if (got !== exp || locked !== 1'b1) begin
        failures++;
        $display("FAIL bad_chan t=%0d got=%b exp=%b", cyc - t0, got, exp);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    int k;
    k = $urandom_range(1, 4);
    repeat (k) tick();
    rst = 1'b1;
    tick();
    checks++;
    got = {outclk, outclk_stb, locked, cfg_ready};
    if (got !== 8'h00) begin
      failures++;
      $display("FAIL mid_reset_values got=%b exp=%b", got, 8'h00);
    end
    rst = 1'b0;
    tick();
    t0 = cyc;
    model_defaults();
    for (int n = 0; n < 90; n++) begin
      got = {outclk, outclk_stb, locked, cfg_ready}; exp = exp_vec(cyc);
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL mid_reset_wave t=%0d got=%b exp=%b", cyc - t0, got, exp);
      end
      tick();
    end
  endtask

  task automatic test_hold_through_reset();
    cfg_valid = 1'b1; cfg_chan = 2'd1;
    cfg_div = 16'd6; cfg_high = 16'd2; cfg_phase = 16'd1;
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    tick();
    t0 = cyc;
    model_defaults();
    for (int n = 0; n < 2; n++) begin
      got = {outclk, outclk_stb, locked, cfg_ready}; exp = exp_vec(cyc);
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL hold_pre_accept t=%0d got=%b exp=%b", cyc - t0, got, exp);
      end
      tick();
    end
    // Accepted on the edge after the first cfg_ready=1 cycle; now in restart.
    cfg_valid = 1'b0;
    checks++;
    if (cfg_ready !== 1'b0) begin
      failures++;
      $display("FAIL hold_accept_ready got=%b exp=0", cfg_ready);
    end
    m_div[1] = 6; m_high[1] = 2; m_phase[1] = 1;
    t0 = cyc + 1;
    for (int n = 0; n < 25; n++) begin
      tick();
      got = {outclk, outclk_stb, locked, cfg_ready}; exp = exp_vec(cyc);
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL hold_post_accept t=%0d got=%b exp=%b", cyc - t0, got, exp);
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int w = 0; w < 3; w++) begin
      cfg_write($urandom_range(0, 2), $urandom_range(0, 12), $urandom_range(0, 14),
                $urandom_range(0, 14));
      checks++;
      if (locked !== 1'b0 || cfg_ready !== 1'b0) begin
        failures++;
        $display("FAIL b2b_start w=%0d got=%b%b exp=00", w, locked, cfg_ready);
      end
    end
    for (int n = 0; n < 110; n++) begin
      tick();
      got = {outclk, outclk_stb, locked, cfg_ready}; exp = exp_vec(cyc);
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL b2b_wave t=%0d got=%b exp=%b", cyc - t0, got, exp);
      end
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 4; it++) begin
      cfg_write($urandom_range(0, 3), $urandom_range(0, 9), $urandom_range(0, 11),
                $urandom_range(0, 11));
      for (int n = 0; n < 30; n++) begin
        tick();
        got = {outclk, outclk_stb, locked, cfg_ready}; exp = exp_vec(cyc);
        checks++;
        // Skip the restart cycle itself; its outputs belong to the old setup.
        if (cyc >= t0 && got !== exp) begin
          failures++;
          $display("FAIL random_wave it=%0d t=%0d got=%b exp=%b", it, cyc - t0, got, exp);
        end
      end
    end
  endtask

  initial begin
    model_defaults();
    test_reset();
    test_reconfig();
    test_clamp();
    test_bad_chan();
    test_reset_mid();
    test_hold_through_reset();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
